// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg
//   Shared definitions for the instruction sequencer: the FSM state
//   encoding, the decoded opcode values and the register-file write
//   source selectors driven on in_data.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    A_RD1  = 4'd2,
    A_LD1  = 4'd3,
    A_RD2  = 4'd4,
    A_LD2  = 4'd5,
    A_SAV  = 4'd6,
    A_WB   = 4'd7,
    L_INC  = 4'd8,
    L_WAIT = 4'd9,
    L_WB   = 4'd10,
    NOP    = 4'd11,
    HALT   = 4'd12,
    TRAP   = 4'd13
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDN  = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] IN_MEM = 2'd0;
  localparam logic [1:0] IN_ALU = 2'd1;

endpackage

// File: rtl/control_fsm.sv
// control_fsm
//   Instruction sequencer for a small register-file/ALU datapath. Fetches a
//   word when mem_ready is high, keeps a private copy of it and walks the
//   datapath through the ALU, load-next, NOP or halt sequence. All outputs
//   are Moore-decoded from the state and the saved instruction, so the
//   memory bus may change freely once the word has been fetched.
//
//   Build option: define CONTROL_FSM_ILLEGAL_TRAP_EN to park the sequencer
//   in TRAP (illegal=1) on an unknown opcode. Without it, unknown opcodes
//   behave as NOP and TRAP is never entered.
//
//   Ports
//     clk, rst_n     clock, asynchronous active-low reset
//     instruction    word presented by memory
//     mem_ready      instruction valid this cycle
//     write_reg      register-file write strobe
//     reg_addr       register-file address (rd or rs field)
//     write_op1/2    ALU operand latch strobes
//     alu_act        ALU operation select
//     save_alu_res   ALU result latch strobe
//     in_data        register write source (IN_MEM / IN_ALU)
//     counter_en     program-counter increment
//     sys_rst        datapath reset, high in INIT
//     halted/illegal status flags
//
//   state  | meaning
//   INIT   | datapath held in reset
//   FETCH  | wait for mem_ready, capture and decode word
//   A_RD1  | address rd for operand 1
//   A_LD1  | latch operand 1
//   A_RD2  | address rs for operand 2
//   A_LD2  | latch operand 2, present ALU action
//   A_SAV  | latch ALU result
//   A_WB   | write ALU result to rd, advance PC
//   L_INC  | advance PC to the data word
//   L_WAIT | wait for data word
//   L_WB   | write memory word to rd, advance PC
//   NOP    | advance PC only
//   HALT   | stopped until reset
//   TRAP   | illegal opcode, stopped until reset
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4,
  parameter int REG_AW = 4,
  parameter int ALU_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instruction,
  input  logic              mem_ready,
  output logic              write_reg,
  output logic [REG_AW-1:0] reg_addr,
  output logic              write_op1,
  output logic              write_op2,
  output logic [ALU_W-1:0]  alu_act,
  output logic              save_alu_res,
  output logic [1:0]        in_data,
  output logic              counter_en,
  output logic              sys_rst,
  output logic              halted,
  output logic              illegal
);

  localparam int FIELD_W = OPC_W + 2 * REG_AW + ALU_W;
  localparam int RD_HI   = DATA_W - OPC_W - 1;
  localparam int RS_HI   = RD_HI - REG_AW;
  localparam int ALU_HI  = RS_HI - REG_AW;

  if (DATA_W < FIELD_W) begin : g_bad_widths
    $error("control_fsm: DATA_W too small for opcode, rd, rs and alu fields");
  end

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] saved_instr;
  logic [OPC_W-1:0]  opcode_in;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [ALU_W-1:0]  alu_field;

  // Decode looks at the live bus in FETCH; everything afterwards uses the
  // captured copy.
  assign opcode_in = instruction[DATA_W-1 -: OPC_W];
  assign rd        = saved_instr[RD_HI -: REG_AW];
  assign rs        = saved_instr[RS_HI -: REG_AW];
  assign alu_field = saved_instr[ALU_HI -: ALU_W];

  // Low-order bits below the alu field carry no meaning for this sequencer.
  if (DATA_W > FIELD_W) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^saved_instr[DATA_W-FIELD_W-1:0] ^ saved_instr[DATA_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      saved_instr <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH && mem_ready) begin
        saved_instr <= instruction;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:  next_state = FETCH;
      FETCH: begin
        if (mem_ready) begin
          case (opcode_in)
            OPC_W'(OP_NOP):  next_state = NOP;
            OPC_W'(OP_ALU):  next_state = A_RD1;
            OPC_W'(OP_LDN):  next_state = L_INC;
            OPC_W'(OP_HALT): next_state = HALT;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            default:         next_state = TRAP;
`else
            default:         next_state = NOP;
`endif
          endcase
        end
      end
      A_RD1:  next_state = A_LD1;
      A_LD1:  next_state = A_RD2;
      A_RD2:  next_state = A_LD2;
      A_LD2:  next_state = A_SAV;
      A_SAV:  next_state = A_WB;
      A_WB:   next_state = FETCH;
      L_INC:  next_state = L_WAIT;
      L_WAIT: next_state = mem_ready ? L_WB : L_WAIT;
      L_WB:   next_state = FETCH;
      NOP:    next_state = FETCH;
      HALT:   next_state = HALT;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
      TRAP:   next_state = TRAP;
`endif
      // Includes TRAP when the trap option is not built, so a corrupted
      // register can never strand the sequencer there.
      default: next_state = INIT;
    endcase
  end

  always_comb begin
    write_reg    = 1'b0;
    reg_addr     = '0;
    write_op1    = 1'b0;
    write_op2    = 1'b0;
    alu_act      = '0;
    save_alu_res = 1'b0;
    in_data      = IN_MEM;
    counter_en   = 1'b0;
    sys_rst      = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    case (state)
      INIT:  sys_rst = 1'b1;
      A_RD1: reg_addr = rd;
      A_LD1: begin
        reg_addr  = rd;
        write_op1 = 1'b1;
      end
      A_RD2: reg_addr = rs;
      A_LD2: begin
        reg_addr  = rs;
        write_op2 = 1'b1;
        alu_act   = alu_field;
      end
      A_SAV: begin
        reg_addr     = rd;
        save_alu_res = 1'b1;
      end
      A_WB: begin
        reg_addr   = rd;
        write_reg  = 1'b1;
        in_data    = IN_ALU;
        counter_en = 1'b1;
      end
      L_INC:  counter_en = 1'b1;
      L_WAIT: reg_addr = rd;
      L_WB: begin
        reg_addr   = rd;
        write_reg  = 1'b1;
        in_data    = IN_MEM;
        counter_en = 1'b1;
      end
      NOP:  counter_en = 1'b1;
      HALT: halted = 1'b1;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
      TRAP: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instruction = '0;
  logic [23:0] instruction_w = '0;
  logic        mem_ready = 1'b0;

  logic        write_reg, write_op1, write_op2, save_alu_res, counter_en, sys_rst, halted, illegal;
  logic [3:0]  reg_addr;
  logic [2:0]  alu_act;
  logic [1:0]  in_data;

  logic        write_reg_w, write_op1_w, write_op2_w, save_alu_res_w, counter_en_w;
  logic        sys_rst_w, halted_w, illegal_w;
  logic [4:0]  reg_addr_w;
  logic [3:0]  alu_act_w;
  logic [1:0]  in_data_w;

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] sb[$];
  logic [18:0] sb_w[$];

  always #5 clk = ~clk;

  control_fsm dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
    .write_reg(write_reg), .reg_addr(reg_addr), .write_op1(write_op1), .write_op2(write_op2),
    .alu_act(alu_act), .save_alu_res(save_alu_res), .in_data(in_data), .counter_en(counter_en),
    .sys_rst(sys_rst), .halted(halted), .illegal(illegal)
  );

  control_fsm #(.DATA_W(24), .OPC_W(4), .REG_AW(5), .ALU_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .instruction(instruction_w), .mem_ready(mem_ready),
    .write_reg(write_reg_w), .reg_addr(reg_addr_w), .write_op1(write_op1_w), .write_op2(write_op2_w),
    .alu_act(alu_act_w), .save_alu_res(save_alu_res_w), .in_data(in_data_w), .counter_en(counter_en_w),
    .sys_rst(sys_rst_w), .halted(halted_w), .illegal(illegal_w)
  );

  logic [16:0] obs;
  logic [18:0] obs_w;
  assign obs = {write_reg, reg_addr, write_op1, write_op2, alu_act, save_alu_res, in_data,
                counter_en, sys_rst, halted, illegal};
  assign obs_w = {write_reg_w, reg_addr_w, write_op1_w, write_op2_w, alu_act_w, save_alu_res_w,
                  in_data_w, counter_en_w, sys_rst_w, halted_w, illegal_w};

  localparam logic [16:0] Z     = 17'h0;
  localparam logic [16:0] B_WR  = 17'h10000;
  localparam logic [16:0] B_O1  = 17'h00800;
  localparam logic [16:0] B_O2  = 17'h00400;
  localparam logic [16:0] B_SAV = 17'h00040;
  localparam logic [16:0] B_ALU = 17'h00010;
  localparam logic [16:0] B_CE  = 17'h00008;
  localparam logic [16:0] B_RST = 17'h00004;
  localparam logic [16:0] B_HLT = 17'h00002;
  localparam logic [16:0] B_ILL = 17'h00001;

  localparam logic [18:0] W_WR  = 19'h40000;
  localparam logic [18:0] W_O1  = 19'h01000;
  localparam logic [18:0] W_O2  = 19'h00800;
  localparam logic [18:0] W_SAV = 19'h00040;
  localparam logic [18:0] W_ALU = 19'h00010;
  localparam logic [18:0] W_CE  = 19'h00008;

  function automatic logic [16:0] A(input logic [3:0] ra);
    return {1'b0, ra, 12'h000};
  endfunction
  function automatic logic [16:0] AL(input logic [2:0] op);
    return {7'h00, op, 7'h00};
  endfunction
  function automatic logic [18:0] AW(input logic [4:0] ra);
    return {1'b0, ra, 13'h0000};
  endfunction
  function automatic logic [18:0] ALW(input logic [3:0] op);
    return {8'h00, op, 7'h00};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    instruction = '0;
    instruction_w = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] got, want;
    rst_n = 1'b0;
    #1;
    sb.push_back(B_RST);
    got = obs; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL reset_t0: got %h want %h", got, want); end
    repeat (2) @(negedge clk);
    sb.push_back(B_RST);
    got = obs; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL reset_held: got %h want %h", got, want); end
    rst_n = 1'b1;
    #1;
    sb.push_back(B_RST);
    got = obs; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL reset_release: got %h want %h", got, want); end
    sb.push_back(Z);
    @(posedge clk); @(negedge clk);
    got = obs; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL reset_to_fetch: got %h want %h", got, want); end
  endtask

  task automatic test_alu();
    logic [15:0] ins[$];
    bit          rdy[$];
    logic [16:0] ex[$];
    logic [16:0] got, want;
    apply_reset();
    ins = '{16'h1232, 16'h1232, 16'h1232, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
            16'hFFFF, 16'hFFFF, 16'hFFFF};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ex  = '{Z, Z, A(4'h2), A(4'h2) | B_O1, A(4'h3), A(4'h3) | B_O2 | AL(3'd1),
            A(4'h2) | B_SAV, A(4'h2) | B_WR | B_ALU | B_CE, Z, Z};
    for (int i = 0; i < ins.size(); i++) begin
      instruction = ins[i]; mem_ready = rdy[i]; sb.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL alu cyc%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_load();
    logic [15:0] ins[$];
    bit          rdy[$];
    logic [16:0] ex[$];
    logic [16:0] got, want;
    apply_reset();
    ins = '{16'h0000, 16'h2500, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ex  = '{Z, B_CE, A(4'h5), A(4'h5), A(4'h5), A(4'h5) | B_WR | B_CE, Z, Z};
    for (int i = 0; i < ins.size(); i++) begin
      instruction = ins[i]; mem_ready = rdy[i]; sb.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL load cyc%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_nop();
    logic [15:0] ins[$];
    bit          rdy[$];
    logic [16:0] ex[$];
    logic [16:0] got, want;
    apply_reset();
    ins = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ex  = '{Z, B_CE, Z, B_CE, Z};
    for (int i = 0; i < ins.size(); i++) begin
      instruction = ins[i]; mem_ready = rdy[i]; sb.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL nop cyc%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] ins[$];
    bit          rdy[$];
    logic [16:0] ex[$];
    logic [16:0] got, want;
    apply_reset();
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    ins = '{16'h0000, 16'h7000, 16'h1232, 16'h0000, 16'h2500};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ex  = '{Z, B_ILL, B_ILL, B_ILL, B_ILL};
`else
    ins = '{16'h0000, 16'h7000, 16'h7000, 16'h7000, 16'h7000};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ex  = '{Z, B_CE, Z, Z, Z};
`endif
    for (int i = 0; i < ins.size(); i++) begin
      instruction = ins[i]; mem_ready = rdy[i]; sb.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL illegal cyc%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins[$];
    bit          rdy[$];
    logic [16:0] ex[$];
    logic [16:0] got, want;
    apply_reset();
    ins = '{16'h1A5E, 16'h1A5E, 16'h2C00, 16'h2C00, 16'h2C00, 16'h2C00, 16'h2C00,
            16'h2C00, 16'h2C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ex  = '{Z, A(4'hA), A(4'hA) | B_O1, A(4'h5), A(4'h5) | B_O2 | AL(3'd7),
            A(4'hA) | B_SAV, A(4'hA) | B_WR | B_ALU | B_CE, Z,
            B_CE, A(4'hC), A(4'hC) | B_WR | B_CE, Z, B_CE, Z};
    for (int i = 0; i < ins.size(); i++) begin
      instruction = ins[i]; mem_ready = rdy[i]; sb.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL b2b cyc%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ins[$];
    bit          rdy[$];
    logic [16:0] ex[$];
    logic [16:0] got, want;
    apply_reset();
    ins = '{16'h0000, 16'h1232, 16'h1232, 16'h1232, 16'h1232};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ex  = '{Z, A(4'h2), A(4'h2) | B_O1, A(4'h3), A(4'h3) | B_O2 | AL(3'd1)};
    for (int i = 0; i < ins.size(); i++) begin
      instruction = ins[i]; mem_ready = rdy[i]; sb.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL midrst_pre cyc%0d: got %h want %h", i, got, want); end
    end
    rst_n = 1'b0;
    #1;
    sb.push_back(B_RST);
    got = obs; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL midrst_async: got %h want %h", got, want); end
    @(negedge clk);
    rst_n = 1'b1;
    ins = '{16'h0000, 16'h0000, 16'h0000};
    rdy = '{1'b0, 1'b1, 1'b0};
    ex  = '{Z, B_CE, Z};
    for (int i = 0; i < ins.size(); i++) begin
      instruction = ins[i]; mem_ready = rdy[i]; sb.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL midrst_post cyc%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_halt();
    logic [15:0] ins[$];
    bit          rdy[$];
    logic [16:0] ex[$];
    logic [16:0] got, want;
    apply_reset();
    ins = '{16'h0000, 16'hF000, 16'h1232, 16'h0000, 16'h2500, 16'h7000, 16'h0000};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ex  = '{Z, B_HLT, B_HLT, B_HLT, B_HLT, B_HLT, B_HLT};
    for (int i = 0; i < ins.size(); i++) begin
      instruction = ins[i]; mem_ready = rdy[i]; sb.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL halt cyc%0d: got %h want %h", i, got, want); end
    end
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    sb.push_back(B_RST);
    got = obs; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL halt_reset: got %h want %h", got, want); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(Z);
    @(posedge clk); @(negedge clk);
    got = obs; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL halt_refetch: got %h want %h", got, want); end
  endtask

  task automatic test_wide();
    logic [23:0] ins[$];
    bit          rdy[$];
    logic [18:0] ex[$];
    logic [18:0] got, want;
    apply_reset();
    // 0x1218A6 with 5-bit registers: rd=4, rs=6, alu=2.
    ins = '{24'h000000, 24'h1218A6, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
            24'hFFFFFF, 24'hFFFFFF};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ex  = '{19'h0, AW(5'd4), AW(5'd4) | W_O1, AW(5'd6), AW(5'd6) | W_O2 | ALW(4'd2),
            AW(5'd4) | W_SAV, AW(5'd4) | W_WR | W_ALU | W_CE, 19'h0};
    for (int i = 0; i < ins.size(); i++) begin
      instruction_w = ins[i]; mem_ready = rdy[i]; sb_w.push_back(ex[i]);
      @(posedge clk); @(negedge clk);
      got = obs_w; want = sb_w.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL wide cyc%0d: got %h want %h", i, got, want); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_nop();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
